down_count_timer: RTL and testbench

- Programmable down-counting timer: loads a start value, decrements once per clock, and pulses `expire` when the count reaches zero.
- Mirrors the team's free-running up counter in the opposite direction. Adds one-shot and auto-reload modes, pause, abort and retrigger.
- Sits beside the up counter as the timeout/interval generator for control logic.

---
 rtl/counter_pkg.sv | 13 +
 rtl/down_count_timer.sv | 101 ++++++++++
 tb/tb_down_count_timer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up and down counters: controller state
// encoding and the default count width.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_t;

  localparam int COUNT_W = 4;

endpackage

// File: rtl/down_count_timer.sv
// Programmable down-counting timer. A start strobe with a non-zero value
// loads the count; the count then decrements once per clock and a
// registered one-cycle expire pulse follows the edge on which the count
// leaves 1. One-shot mode returns to IDLE; auto-reload mode restarts from
// the value captured at the last accepted start.
//
// Control semantics: start, pause and abort are sampled on every rising
// edge with priority abort > start > pause > decrement. There is no
// back-pressure; a start held high simply retriggers on every edge, and a
// start carrying a zero value is ignored as if it were absent.
// dbg_state exposes the controller state register for observation.
module down_count_timer
  import counter_pkg::*;
#(
  parameter int W = COUNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] load_val,
  input  logic         auto_reload,
  input  logic         pause,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         paused,
  output logic         expire,
  output logic [1:0]   dbg_state
);

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_n;
  logic [W-1:0] count_n;
  logic [W-1:0] reload, reload_n;
  logic         mode, mode_n;
  logic         expire_n;

  // State, datapath and expire registers; asynchronous clear to idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      mode   <= 1'b0;
      expire <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      mode   <= mode_n;
      expire <= expire_n;
    end
  end

  // Next-state and next-datapath decode following the edge priority chain.
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    mode_n   = mode;
    expire_n = 1'b0;
    if (abort) begin
      // Abort wins over everything, including a terminal count.
      state_n = IDLE;
      count_n = '0;
    end else if (start && (load_val != '0)) begin
      // Accepted start (or retrigger); any terminal event is discarded.
      state_n  = RUN;
      count_n  = load_val;
      reload_n = load_val;
      mode_n   = auto_reload;
    end else if (state != IDLE) begin
      if (pause) begin
        state_n = HOLD;
      end else if (count > ONE) begin
        state_n = RUN;
        count_n = count - ONE;
      end else if (count == ONE) begin
        expire_n = 1'b1;
        if (mode) begin
          state_n = RUN;
          count_n = reload;
        end else begin
          state_n = IDLE;
          count_n = '0;
        end
      end else begin
        // A zero count while active cannot arise from an accepted start;
        // fall back to idle rather than wrapping.
        state_n = IDLE;
        count_n = '0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign paused    = (state == HOLD);
  assign dbg_state = state;

endmodule

// File: tb/tb_down_count_timer.sv
// Testbench for down_count_timer: directed scenarios with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_down_count_timer;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] load_val;
  logic         auto_reload;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         paused;
  logic         expire;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  down_count_timer #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .paused     (paused),
    .expire     (expire),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Timer described by its observable meaning: how much count remains,
  // whether it is active, frozen, and which period it restarts with.
  int m_count, m_reload;
  bit m_mode, m_active, m_frozen, m_expire;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_count = 0; m_reload = 0; m_mode = 0;
      m_active = 0; m_frozen = 0; m_expire = 0;
    end else begin
      m_expire = 0;
      if (abort) begin
        m_active = 0; m_frozen = 0; m_count = 0;
      end else if (start && load_val != '0) begin
        m_count = int'(load_val); m_reload = int'(load_val);
        m_mode = auto_reload; m_active = 1; m_frozen = 0;
      end else if (m_active) begin
        if (pause) m_frozen = 1;
        else begin
          m_frozen = 0;
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_expire = 1;
            if (m_mode) m_count = m_reload;
            else m_active = 0;
          end
        end
      end
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("model_count",  32'(count),     32'(m_count));
      chk("model_busy",   32'(busy),      32'(m_active));
      chk("model_paused", 32'(paused),    32'(m_frozen));
      chk("model_expire", 32'(expire),    32'(m_expire));
      chk("model_state",  32'(dbg_state), m_frozen ? 32'd2 : (m_active ? 32'd1 : 32'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    start = 0; load_val = '0; auto_reload = 0; pause = 0; abort = 0;
  endtask

  task automatic do_start(input logic [W-1:0] v, input logic ar);
    start = 1; load_val = v; auto_reload = ar;
    cyc();
    start = 0; load_val = '0; auto_reload = 0;
  endtask

  task automatic do_abort();
    abort = 1;
    cyc();
    abort = 0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int pulses;
    int waited;
    bit seen;
    rst = 0;
    idle_inputs();
    cyc(); cyc();
    rst = 1;
    cyc();
    chk("reset_count",  32'(count),  32'd0);
    chk("reset_busy",   32'(busy),   32'd0);
    chk("reset_paused", 32'(paused), 32'd0);
    chk("reset_expire", 32'(expire), 32'd0);

    // Asynchronous reset mid-run with count=7.
    do_start(4'd9, 1'b0);
    cyc(); cyc();
    chk("pre_reset_count", 32'(count), 32'd7);
    #2 rst = 0;
    #1;
    chk("async_reset_count",  32'(count),  32'd0);
    chk("async_reset_busy",   32'(busy),   32'd0);
    chk("async_reset_expire", 32'(expire), 32'd0);
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("post_reset_count", 32'(count), 32'd0);
      chk("post_reset_busy",  32'(busy),  32'd0);
    end

    // One-shot with 5.
    do_start(4'd5, 1'b0);
    chk("oneshot_load", 32'(count), 32'd5);
    chk("oneshot_busy", 32'(busy),  32'd1);
    exp_q = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cyc();
      chk("oneshot_count", 32'(count), 32'(e));
      chk("oneshot_expire", 32'(expire), (e == 4'd0) ? 32'd1 : 32'd0);
      chk("oneshot_busy_seq", 32'(busy), (e == 4'd0) ? 32'd0 : 32'd1);
    end
    cyc();
    chk("oneshot_after_expire", 32'(expire), 32'd0);
    chk("oneshot_after_count",  32'(count),  32'd0);

    // Auto-reload with 3 over 12 cycles.
    do_start(4'd3, 1'b1);
    pulses = 0;
    exp_q = '{4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3};
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cyc();
      chk("auto_count", 32'(count), 32'(e));
      chk("auto_busy",  32'(busy),  32'd1);
      if (expire) pulses++;
    end
    chk("auto_pulses", 32'(pulses), 32'd4);
    do_abort();
    chk("auto_abort_busy", 32'(busy), 32'd0);

    // Pause for 3 cycles at count=2; expire 7 edges after the start edge.
    do_start(4'd4, 1'b0);
    waited = 0;
    cyc(); waited++;
    cyc(); waited++;
    chk("pause_pre_count", 32'(count), 32'd2);
    pause = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); waited++;
      chk("pause_hold_count", 32'(count),  32'd2);
      chk("pause_paused",     32'(paused), 32'd1);
    end
    pause = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cyc(); waited++;
      if (expire) seen = 1;
    end
    chk("pause_expire_seen", 32'(seen),   32'd1);
    chk("pause_expire_time", 32'(waited), 32'd7);
    chk("pause_final_count", 32'(count),  32'd0);

    // Abort and start together on the terminal edge.
    do_start(4'd2, 1'b0);
    cyc();
    chk("prio_pre_count", 32'(count), 32'd1);
    abort = 1; start = 1; load_val = 4'd6;
    cyc();
    idle_inputs();
    chk("prio_count",  32'(count),  32'd0);
    chk("prio_busy",   32'(busy),   32'd0);
    chk("prio_expire", 32'(expire), 32'd0);
    cyc();
    chk("prio_expire_late", 32'(expire), 32'd0);

    // Retrigger at count=2, and again at count=1.
    do_start(4'd3, 1'b0);
    cyc();
    do_start(4'd9, 1'b0);
    chk("retrig_count",  32'(count),  32'd9);
    chk("retrig_expire", 32'(expire), 32'd0);
    do_abort();
    do_start(4'd2, 1'b0);
    cyc();
    do_start(4'd5, 1'b0);
    chk("retrig_term_count",  32'(count),  32'd5);
    chk("retrig_term_expire", 32'(expire), 32'd0);
    do_abort();

    // Zero load: ignored from idle and while running.
    do_start(4'd0, 1'b1);
    chk("zero_idle_count",  32'(count),  32'd0);
    chk("zero_idle_busy",   32'(busy),   32'd0);
    chk("zero_idle_expire", 32'(expire), 32'd0);
    do_start(4'd3, 1'b0);
    do_start(4'd0, 1'b1);
    chk("zero_run_count", 32'(count), 32'd2);
    do_abort();

    // Auto-reload with 1: expire stays high.
    do_start(4'd1, 1'b1);
    chk("n1_load_expire", 32'(expire), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("n1_expire", 32'(expire), 32'd1);
      chk("n1_count",  32'(count),  32'd1);
    end
    do_abort();

    // Mixed soak checked by the model alone.
    for (int i = 0; i < 300; i++) begin
      abort       = ($urandom_range(0, 24) == 0);
      start       = ($urandom_range(0, 7) == 0);
      load_val    = W'($urandom_range(0, 15));
      auto_reload = 1'($urandom_range(0, 1));
      pause       = ($urandom_range(0, 4) == 0);
      cyc();
    end
    idle_inputs();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
